// File: rtl/mips_isa_pkg.sv
// ============================================================================
// mips_isa_pkg : instruction kinds, MIPS opcode/funct constants, loader states
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_isa_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLL  = 4'd4,
    KIND_SRL  = 4'd5,
    KIND_SLT  = 4'd6,
    KIND_ADDI = 4'd7,
    KIND_ANDI = 4'd8,
    KIND_ORI  = 4'd9,
    KIND_LW   = 4'd10,
    KIND_SW   = 4'd11,
    KIND_BEQ  = 4'd12,
    KIND_BNE  = 4'd13
  } op_kind_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  // Zero words appended after a session when pipeline-flush padding is built in
  localparam int NOP_PAD = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } load_state_e;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encode.sv
// ============================================================================
// instr_encode : combinational symbolic instruction -> 32-bit MIPS word
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind)
      KIND_ADD:  word = enc_r(rs, rt, rd, 5'd0, FN_ADD);
      KIND_SUB:  word = enc_r(rs, rt, rd, 5'd0, FN_SUB);
      KIND_AND:  word = enc_r(rs, rt, rd, 5'd0, FN_AND);
      KIND_OR:   word = enc_r(rs, rt, rd, 5'd0, FN_OR);
      KIND_SLT:  word = enc_r(rs, rt, rd, 5'd0, FN_SLT);
      // Shifts take their operand from rt; rs is architecturally zero
      KIND_SLL:  word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
      KIND_SRL:  word = enc_r(5'd0, rt, rd, shamt, FN_SRL);
      KIND_ADDI: word = enc_i(OPC_ADDI, rs, rt, imm);
      KIND_ANDI: word = enc_i(OPC_ANDI, rs, rt, imm);
      KIND_ORI:  word = enc_i(OPC_ORI,  rs, rt, imm);
      KIND_LW:   word = enc_i(OPC_LW,   rs, rt, imm);
      KIND_SW:   word = enc_i(OPC_SW,   rs, rt, imm);
      KIND_BEQ:  word = enc_i(OPC_BEQ,  rs, rt, imm);
      KIND_BNE:  word = enc_i(OPC_BNE,  rs, rt, imm);
      default:   illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// instr_encoder_loader : streams encoded instructions into instruction memory
//                        (optional pipeline-flush padding: ENCODER_NOP_PAD_EN)
// Revision             : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        op_rs,
  input  logic [4:0]        op_rt,
  input  logic [4:0]        op_rd,
  input  logic [4:0]        op_shamt,
  input  logic [15:0]       op_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W+1:0] c_depth = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);

  load_state_e r_state;
  load_state_e w_state_nxt;

  logic [31:0]     w_word;
  logic            w_illegal;
  logic [ADDR_W+1:0] w_pending;
  logic [CW-1:0]   w_count_nxt;
  logic            w_complete;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_full_nxt;
  logic            w_pad_issue;
  logic            w_enter_done;

  instr_encode u_encode (
    .kind    (op_kind),
    .rs      (op_rs),
    .rt      (op_rt),
    .rd      (op_rd),
    .shamt   (op_shamt),
    .imm     (op_imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  // Words committed plus the one in the write slot, if any
  assign w_pending   = (ADDR_W+2)'(word_count) + (ADDR_W+2)'(imem_we);
  assign w_complete  = imem_we & imem_ready;
  assign w_slot_free = ~imem_we | imem_ready;
  assign w_count_nxt = word_count + CW'(w_complete);
  assign w_full_nxt  = (ADDR_W+2)'(w_count_nxt) >= c_depth;

  assign op_ready = (r_state == ST_ACTIVE) && w_slot_free && (w_pending < c_depth)
                    && !load_start && !load_end;
  assign w_accept = op_valid & op_ready;
  assign load_busy = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);

`ifdef ENCODER_NOP_PAD_EN
  logic [1:0] r_pad_left;

  assign w_pad_issue = (r_state == ST_DRAIN) && w_slot_free && (r_pad_left != 2'd0)
                       && ((ADDR_W+2)'(w_count_nxt) < c_depth);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_left <= 2'd0;
    end else if (load_start || ((r_state == ST_ACTIVE) && load_end)) begin
      r_pad_left <= 2'(NOP_PAD);
    end else if (w_pad_issue) begin
      r_pad_left <= r_pad_left - 2'd1;
    end
  end
`else
  assign w_pad_issue = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      w_state_nxt = ST_ACTIVE;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_full_nxt)    w_state_nxt = ST_DONE;
          else if (load_end) w_state_nxt = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_slot_free && !w_pad_issue) w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
    end else begin
      r_state     <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_we     <= 1'b0;
      imem_addr   <= c_base;
      imem_wdata  <= '0;
      word_count  <= '0;
      load_done   <= 1'b0;
      err_illegal <= 1'b0;
    end else if (load_start) begin
      // A new session abandons any write still sitting in the slot
      imem_we     <= 1'b0;
      imem_addr   <= c_base;
      word_count  <= '0;
      load_done   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      if (w_complete) begin
        word_count <= w_count_nxt;
        imem_addr  <= imem_addr + ADDR_W'(1);
      end
      if (w_accept && !w_illegal) begin
        imem_we    <= 1'b1;
        imem_wdata <= w_word;
      end else if (w_pad_issue) begin
        imem_we    <= 1'b1;
        imem_wdata <= '0;
      end else if (w_complete) begin
        imem_we    <= 1'b0;
      end
      if (w_accept && w_illegal) err_illegal <= 1'b1;
      if (w_enter_done)          load_done   <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// tb_instr_encoder_loader : scoreboard bench with a field-table reference model
// Revision                : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 10;
  localparam int BASE_ADDR = 3;
`ifdef ENCODER_NOP_PAD_EN
  localparam int PAD = 3;
`else
  localparam int PAD = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic load_start = 1'b0, load_end = 1'b0, op_valid = 1'b0, imem_ready = 1'b0;
  logic [3:0]  op_kind = '0;
  logic [4:0]  op_rs = '0, op_rt = '0, op_rd = '0, op_shamt = '0;
  logic [15:0] op_imm = '0;
  logic op_ready, imem_we, load_busy, load_done, err_illegal;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_end(load_end),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_rs(op_rs),
    .op_rt(op_rt), .op_rd(op_rd), .op_shamt(op_shamt), .op_imm(op_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .load_busy(load_busy), .load_done(load_done),
    .word_count(word_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  int n_pass = 0, n_total = 0;
  int sess_words = 0;
  bit model_err = 1'b0;
  bit sess_closed = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Reference encoding straight from the ISA field tables
  function automatic logic [31:0] ref_word(int k, int rs, int rt, int rd, int sh, int imm);
    int fn[7];
    int opc[7];
    longint w;
    fn  = '{32, 34, 36, 37, 0, 2, 42};
    opc = '{8, 12, 13, 35, 43, 4, 5};
    if (k < 7) begin
      if (k == 4 || k == 5) rs = 0; else sh = 0;
      w = longint'(rs) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * 64 + fn[k];
    end else begin
      w = longint'(opc[k-7]) * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    end
    return w[31:0];
  endfunction

  task automatic model_accept(input int k, rs, rt, rd, sh, imm, input logic [32:0] forced);
    wr_t w;
    if (k > 13) begin
      model_err = 1'b1;
    end else begin
      w.addr = ADDR_W'(BASE_ADDR + sess_words);
      w.data = forced[32] ? forced[31:0] : ref_word(k, rs, rt, rd, sh, imm);
      exp_q.push_back(w);
      sess_words++;
    end
  endtask

  task automatic cycle(input bit v, input int k, rs, rt, rd, sh, imm, input bit rdy,
                       input bit ls, input bit le, input logic [32:0] forced, output bit acc);
    @(negedge clk);
    op_valid = v; op_kind = 4'(k); op_rs = 5'(rs); op_rt = 5'(rt); op_rd = 5'(rd);
    op_shamt = 5'(sh); op_imm = 16'(imm); imem_ready = rdy; load_start = ls; load_end = le;
    #1;
    if (!ls && (sess_closed || sess_words >= DEPTH))
      check(op_ready == 1'b0, "ready_closed", op_ready, 0);
    acc = v && op_ready;
    if (acc) model_accept(k, rs, rt, rd, sh, imm, forced);
  endtask

  task automatic rand_cycle(input bit le, output bit acc);
    cycle(($urandom % 4) != 0, $urandom_range(0, 15), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 65535), ($urandom % 4) != 0, 1'b0, le, 33'd0, acc);
  endtask

  task automatic issue(input int k, rs, rt, rd, sh, imm, input logic [32:0] forced,
                       output int tries);
    bit acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      cycle(1'b1, k, rs, rt, rd, sh, imm, 1'b1, 1'b0, 1'b0, forced, acc);
      tries++;
    end
    if (!acc) check(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic start_session();
    bit acc;
    sess_words = 0; model_err = 1'b0; sess_closed = 1'b0;
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 33'd0, acc);
  endtask

  task automatic end_session(input bit use_end);
    bit acc;
    int i;
    if (use_end) begin
      cycle(1'b1, 0, 1, 2, 3, 0, 0, ($urandom % 2) != 0, 1'b0, 1'b1, 33'd0, acc);
      check(op_ready == 1'b0, "ready_on_end", op_ready, 0);
      sess_closed = 1'b1;
      for (int p = 0; p < PAD && sess_words < DEPTH; p++)
        model_accept(0, 0, 0, 0, 0, 0, {1'b1, 32'd0});
    end
    i = 0;
    while (!load_done && i < 300) begin
      rand_cycle(1'b0, acc);
      i++;
    end
    if (!load_done) check(1'b0, "done_timeout", load_done, 1);
    sess_closed = 1'b1;
    check(load_busy == 1'b0, "busy_after_done", load_busy, 0);
    check(word_count == (ADDR_W+1)'(sess_words), "word_count", word_count, sess_words);
    check(err_illegal == model_err, "err_illegal", err_illegal, model_err);
    check(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard pop on every completed write, plus slot-hold checks
  initial begin
    logic p_we, p_rdy;
    logic [ADDR_W-1:0] p_addr;
    logic [31:0] p_data;
    wr_t w;
    p_we = 1'b0; p_rdy = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        p_we = 1'b0;
      end else begin
        if (p_we && !p_rdy) begin
          check(imem_we == 1'b1, "hold_we", imem_we, 1);
          check(imem_addr == p_addr, "hold_addr", imem_addr, p_addr);
          check(imem_wdata == p_data, "hold_wdata", imem_wdata, p_data);
        end
        if (imem_we && imem_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_write", imem_addr, 0);
          end else begin
            w = exp_q.pop_front();
            check(imem_addr == w.addr, "write_addr", imem_addr, w.addr);
            check(imem_wdata == w.data, "write_data", imem_wdata, w.data);
          end
        end
        p_we = imem_we; p_rdy = imem_ready; p_addr = imem_addr; p_data = imem_wdata;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries;

    repeat (3) @(negedge clk);
    #1;
    check(imem_we == 1'b0, "rst_we", imem_we, 0);
    check(imem_addr == ADDR_W'(BASE_ADDR), "rst_addr", imem_addr, BASE_ADDR);
    check(word_count == '0, "rst_count", word_count, 0);
    check({load_busy, load_done, err_illegal, op_ready} == 4'b0, "rst_status",
          {load_busy, load_done, err_illegal, op_ready}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed session: known encodings, latency, back-to-back, stall, illegal
    start_session();
    issue(0, 1, 2, 3, 0, 0, {1'b1, 32'h00221820}, tries);
    @(posedge clk);
    #1;
    check(imem_we == 1'b1, "latency_we", imem_we, 1);
    check(imem_addr == ADDR_W'(BASE_ADDR), "latency_addr", imem_addr, BASE_ADDR);
    issue(10, 9, 8, 0, 0, 4, {1'b1, 32'h8D280004}, tries);
    check(tries == 1, "b2b_lw", tries, 1);
    issue(12, 1, 2, 0, 0, 16'hFFFF, {1'b1, 32'h1022FFFF}, tries);
    check(tries == 1, "b2b_beq", tries, 1);
    repeat (2) cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 33'd0, acc);
    check(word_count == 3, "count_after_b2b", word_count, 3);
    issue(4, 7, 3, 2, 4, 0, {1'b1, 32'h00031100}, tries);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1, 0, 1, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 33'd0, acc);
      check(op_ready == 1'b0, "stall_ready", op_ready, 0);
    end
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 33'd0, acc);
    issue(14, 1, 2, 3, 0, 0, 33'd0, tries);
    @(posedge clk);
    #1;
    check(err_illegal == 1'b1, "illegal_flag", err_illegal, 1);
    check(imem_we == 1'b0, "illegal_no_write", imem_we, 0);
    issue(0, 4, 5, 6, 0, 0, 33'd0, tries);
    end_session(1'b1);

    // Illegal kind first in a fresh session: next word still lands at the base
    start_session();
    issue(15, 3, 3, 3, 3, 3, 33'd0, tries);
    issue(0, 1, 2, 3, 0, 0, {1'b1, 32'h00221820}, tries);
    end_session(1'b1);

    // Randomised sessions, some long enough to fill memory
    for (int n = 0; n < 8; n++) begin
      int target, got, guard;
      target = (n % 3 == 0) ? DEPTH + 4 : $urandom_range(1, DEPTH + 2);
      got = 0; guard = 0;
      start_session();
      while (got < target && sess_words < DEPTH && guard < 400) begin
        rand_cycle(1'b0, acc);
        if (acc) got++;
        guard++;
      end
      end_session(sess_words < DEPTH);
      if (sess_words >= DEPTH)
        check(load_done == 1'b1, "full_done", load_done, 1);
    end

    // Asynchronous reset while a write is held in the slot
    start_session();
    issue(7, 1, 2, 0, 0, 16'h1234, 33'd0, tries);
    cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 33'd0, acc);
    check(imem_we == 1'b1, "pre_reset_we", imem_we, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check(imem_we == 1'b0, "async_reset_we", imem_we, 0);
    exp_q.delete();
    sess_words = 0; model_err = 1'b0; sess_closed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    cycle(1'b1, 0, 1, 2, 3, 0, 0, 1'b1, 1'b0, 1'b1, 33'd0, acc);
    @(posedge clk);
    #1;
    check(load_busy == 1'b0, "idle_after_reset", load_busy, 0);
    check(word_count == '0, "count_after_reset", word_count, 0);
    check(load_done == 1'b0, "end_ignored_idle", load_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streams symbolic instructions (kind plus register and immediate fields) in through a valid/ready handshake. Each one is encoded into a 32-bit MIPS word and written sequentially into instruction memory. This is the inverse of the main control/instruction decode path, and it is the boot and test-program loader for the processor. A single write slot is held until memory accepts it, and a load-session FSM sits around that slot.

Parameters:
ADDR_W, 8, instruction memory word-address width
DEPTH, 256, words available; loader stops at DEPTH (DEPTH <= 2**ADDR_W)
BASE_ADDR, 0, first word address written after load_start

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
load_start  in  1  one-cycle pulse; opens a load session
load_end  in  1  one-cycle pulse; closes session after pending write
op_valid  in  1  instruction fields valid
op_ready  out  1  loader accepts fields this cycle
op_kind  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRL,6 SLT,7 ADDI,8 ANDI,9 ORI,10 LW,11 SW,12 BEQ,13 BNE; 14-15 illegal
op_rs, op_rt, op_rd, op_shamt  in  5 each  register and shift fields
op_imm  in  16  immediate or branch offset, passed unmodified
imem_we  out  1  write request
imem_ready  in  1  memory accepts write this cycle
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
load_busy  out  1  session open
load_done  out  1  sticky until next load_start
word_count  out  ADDR_W+1  words written this session
err_illegal  out  1  sticky; illegal kind seen

Behaviour:
- Reset: state IDLE; all outputs 0; imem_addr = BASE_ADDR.
- States: IDLE, ACTIVE, DRAIN, DONE.
  - load_start in any state enters ACTIVE, clears word_count, load_done and err_illegal, and sets imem_addr to BASE_ADDR.
  - load_start in the same cycle as load_end: load_start wins.
- op_ready = (state == ACTIVE) && (!imem_we || imem_ready) && (word_count + imem_we < DEPTH).
  - This is a combinational function of imem_ready.
- On accept (op_valid && op_ready), the encoded word is registered next cycle: imem_we = 1 and imem_wdata set. Latency is 1 cycle.
- While imem_we = 1 and imem_ready = 0: imem_we, imem_addr and imem_wdata hold stable.
- Write completion (imem_we && imem_ready):
  - word_count increments, then imem_addr increments.
  - If there is no simultaneous accept, imem_we drops.
- Back-to-back accept and completion sustain 1 word per cycle.
- Encoding:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}; shamt forced 0 except for SLL/SRL, and rs forced 0 for SLL/SRL.
  - Functs: ADD 20, SUB 22, AND 24, OR 25, SLT 2A, SLL 00, SRL 02 (hex).
  - I-type: {opcode, rs, rt, imm}.
  - Opcodes: ADDI 08, ANDI 0C, ORI 0D, LW 23, SW 2B, BEQ 04, BNE 05 (hex).
- Illegal kind: the handshake still completes, nothing is written, and err_illegal is set.
- Full: once word_count reaches DEPTH, state goes to DONE and load_done = 1. Further op_valid is stalled (op_ready = 0).
- load_end in ACTIVE: the fields offered that cycle are not accepted. State goes to DRAIN until the pending write completes, then DONE.
- load_end in IDLE or DONE is ignored.
- load_busy = ACTIVE or DRAIN.
- Reset mid-session: the write is abandoned and imem_we drops immediately (asynchronous).

Optional Feature:
ENCODER_NOP_PAD_EN:
- Defined: after load_end (or when full), DRAIN appends NOP_PAD (localparam 3) zero words at consecutive addresses before DONE. These flush the pipeline. Padding stops early at DEPTH and counts in word_count.
- Undefined: no padding; DRAIN only completes the pending write.

Decomposition:
- Shared package mips_isa_pkg holds:
  - op_kind enum;
  - 6-bit opcode constants (OPC_RTYPE, OPC_ADDI, ...);
  - funct constants (FN_ADD, ...);
  - loader state typedef.
- Sub-module instr_encode: purely combinational kind+fields -> {word, illegal}; reusable by the decoder's checker bench.

Test Plan:
- load_start; ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, addr 0, wdata 0x00221820.
- LW rs=9 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, back-to-back with imem_ready=1 -> 0x8D280004 at addr 0 and 0x1022FFFF at addr 1; word_count=2.
- SLL rt=3 rd=2 shamt=4 rs=7 with imem_ready=0 for 3 cycles -> wdata 0x00031100 held stable, op_ready=0, then write completes once imem_ready rises.
- op_kind=14 -> err_illegal=1, no imem_we, next ADD lands at addr 0.
- DEPTH=4: stream 6 ops -> 4 writes, load_done=1, op_ready=0 thereafter; with ENCODER_NOP_PAD_EN, load_end after 1 op -> 3 zero words at addrs 1-3.
- reset_n low while imem_we=1 -> imem_we=0 immediately; after release state IDLE, word_count=0.
